// File: rtl/pll_pkg.sv
// Shared constants, lock-supervisor state type and helpers for the
// fractional clock-enable generator.
package pll_pkg;

    // Width of the cfg_ch port, which also caps the channel count at 16.
    localparam int PLL_CH_IDX_W = 4;
    localparam int PLL_MAX_CLOCKS = 16;

    // Widest accumulator the INC_INIT extraction helper can handle.
    localparam int PLL_MAX_ACC_W = 64;
    localparam int PLL_MAX_PACK_W = PLL_MAX_CLOCKS * PLL_MAX_ACC_W;

    // Lock supervisor states. RESET is only seen in the cycle right after
    // reset. Every accepted channel write sends the supervisor back to LOCKING.
    typedef enum logic [1:0] {
        LOCK_RESET   = 2'd0,
        LOCK_LOCKING = 2'd1,
        LOCK_LOCKED  = 2'd2
    } lock_state_e;

    // Lock counter width. The counter must be able to hold LOCK_CYCLES itself.
    function automatic int lock_cnt_w(input int lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

    // Pull channel ch out of a packed per-channel vector.
    // Each channel is acc_w bits wide, and channel 0 sits in the LSBs.
    // The caller zero-extends its vector to PLL_MAX_PACK_W first.
    function automatic logic [PLL_MAX_ACC_W-1:0] pll_extract_inc(
        input logic [PLL_MAX_PACK_W-1:0] packed_vec,
        input int                        ch,
        input int                        acc_w
    );
        logic [PLL_MAX_PACK_W-1:0] shifted;
        logic [PLL_MAX_ACC_W-1:0]  mask;
        shifted = packed_vec >> (ch * acc_w);
        if (acc_w >= PLL_MAX_ACC_W) begin
            mask = '1;
        end else begin
            mask = (PLL_MAX_ACC_W'(1) << acc_w) - PLL_MAX_ACC_W'(1);
        end
        return shifted[PLL_MAX_ACC_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/pll_nco_channel.sv
// One fractional clock-enable channel.
// The phase accumulator adds inc on every running cycle. Each wrap gives
// a one-cycle ce pulse and toggles the square-wave outclk.
module pll_nco_channel #(
    parameter int               ACC_W    = 32,
    parameter logic [ACC_W-1:0] INC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] load_phase,
    input  logic             clear,
    input  logic             run,
    output logic             ce_o,
    output logic             outclk_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] inc_d;
    logic             ce_q;
    logic             ce_d;
    logic             outclk_q;
    logic             outclk_d;
    logic [ACC_W:0]   sum;

    // Accumulator sum is one bit wider than the accumulator, so the top bit is the wrap carry.
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, inc_q};
    end

    // Next state: a load to this channel beats a global clear, and a clear beats normal running.
    always_comb begin
        acc_d    = acc_q;
        inc_d    = inc_q;
        ce_d     = 1'b0;
        outclk_d = outclk_q;
        if (load) begin
            inc_d    = load_inc;
            acc_d    = load_phase;
            outclk_d = 1'b0;
        end else if (clear) begin
            acc_d    = '0;
            outclk_d = 1'b0;
        end else if (run) begin
            acc_d    = sum[ACC_W-1:0];
            ce_d     = sum[ACC_W];
            outclk_d = outclk_q ^ sum[ACC_W];
        end
        if (inc_d == '0) begin
            outclk_d = 1'b0;
        end
    end

    // Channel registers. Reset restores the build-time increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            inc_q    <= INC_INIT;
            ce_q     <= 1'b0;
            outclk_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            ce_q     <= ce_d;
            outclk_q <= outclk_d;
        end
    end

    assign ce_o     = ce_q;
    assign outclk_o = outclk_q;

endmodule

// File: rtl/pll_clken_gen.sv
// Multi-channel fractional clock-enable generator.
// It owns the configuration handshake, the out-of-range error pulse and
// the lock supervisor. The supervisor holds every NCO channel frozen until
// the configuration has been stable for LOCK_CYCLES cycles.
module pll_clken_gen
    import pll_pkg::*;
#(
    parameter int                          NUM_CLOCKS  = 4,
    parameter int                          ACC_W       = 32,
    parameter int                          LOCK_CYCLES = 1024,
    parameter logic [NUM_CLOCKS*ACC_W-1:0] INC_INIT    = '0
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [PLL_CH_IDX_W-1:0] cfg_ch,
    input  logic [ACC_W-1:0]        cfg_inc,
    input  logic [ACC_W-1:0]        cfg_phase,
    output logic                    cfg_err,
    output logic [NUM_CLOCKS-1:0]   ce_o,
    output logic [NUM_CLOCKS-1:0]   outclk,
    output logic                    locked
);

    localparam int LOCK_CNT_W = lock_cnt_w(LOCK_CYCLES);
    localparam logic [LOCK_CNT_W-1:0] LOCK_TARGET = LOCK_CNT_W'(LOCK_CYCLES);
    localparam logic [PLL_MAX_PACK_W-1:0] INC_INIT_EXT = PLL_MAX_PACK_W'(INC_INIT);
    localparam logic [PLL_CH_IDX_W:0] NUM_CLOCKS_EXT = (PLL_CH_IDX_W + 1)'(NUM_CLOCKS);

    // Stop elaboration on unsupported parameter values instead of building wrong hardware.
    if (NUM_CLOCKS < 1 || NUM_CLOCKS > PLL_MAX_CLOCKS) begin : g_bad_num_clocks
        $error("pll_clken_gen: NUM_CLOCKS must be 1..16");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
        $error("pll_clken_gen: LOCK_CYCLES must be at least 1");
    end
    if (ACC_W < 1 || ACC_W > PLL_MAX_ACC_W) begin : g_bad_acc_w
        $error("pll_clken_gen: ACC_W must be 1..64");
    end

    lock_state_e           state_q;
    lock_state_e           state_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q;
    logic [LOCK_CNT_W-1:0] lock_cnt_d;
    logic                  locked_q;
    logic                  locked_d;
    logic                  cfg_ready_q;
    logic                  cfg_ready_d;
    logic                  cfg_err_q;
    logic                  cfg_err_d;

    logic                  wr_fire;
    logic                  ch_in_range;
    logic                  wr_good;
    logic                  wr_bad;

    // Classify the handshake. Only in-range writes touch the channels or the lock.
    always_comb begin
        wr_fire     = cfg_valid & cfg_ready_q;
        ch_in_range = {1'b0, cfg_ch} < NUM_CLOCKS_EXT;
        wr_good     = wr_fire & ch_in_range;
        wr_bad      = wr_fire & ~ch_in_range;
    end

    // Supervisor next state: count up while unlocked, and let a good write
    // restart the lock even in the cycle the count would have completed.
    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        cfg_ready_d = 1'b1;
        cfg_err_d   = wr_bad;

        if (!locked_q && (lock_cnt_q != LOCK_TARGET)) begin
            lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
        end

        case (state_q)
            LOCK_RESET: begin
                state_d = LOCK_LOCKING;
            end
            LOCK_LOCKING: begin
                if (lock_cnt_q == LOCK_TARGET) begin
                    state_d = LOCK_LOCKED;
                end
            end
            LOCK_LOCKED: begin
                state_d = LOCK_LOCKED;
            end
            default: begin
                state_d = LOCK_RESET;
            end
        endcase

        if (wr_good) begin
            state_d    = LOCK_LOCKING;
            lock_cnt_d = '0;
        end

        locked_d = (state_d == LOCK_LOCKED);
    end

    // Supervisor and handshake registers. All top-level outputs come from here or from the channels.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= LOCK_RESET;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // One NCO per channel. Every good write realigns all channels, and only the addressed one takes the new values.
    for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_ch
        localparam logic [ACC_W-1:0] CH_INC_INIT = ACC_W'(pll_extract_inc(INC_INIT_EXT, gi, ACC_W));

        logic ch_load;
        assign ch_load = wr_good && (cfg_ch == PLL_CH_IDX_W'(gi));

        pll_nco_channel #(
            .ACC_W    (ACC_W),
            .INC_INIT (CH_INC_INIT)
        ) u_nco (
            .clk        (refclk),
            .rst        (rst),
            .load       (ch_load),
            .load_inc   (cfg_inc),
            .load_phase (cfg_phase),
            .clear      (wr_good),
            .run        (locked_q),
            .ce_o       (ce_o[gi]),
            .outclk_o   (outclk[gi])
        );
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_pll_clken_gen.sv
// Scoreboard bench for pll_clken_gen.
// The driver predicts every cycle's outputs from an arithmetic rate model
// and queues them. A monitor on the falling edge pops and compares.
module tb_pll_clken_gen;

    localparam int          NCH  = 2;
    localparam int          AW   = 8;
    localparam int          LC   = 4;
    localparam logic [15:0] INIT = {8'h40, 8'h80};

    logic       refclk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_ch;
    logic [7:0] cfg_inc;
    logic [7:0] cfg_phase;
    logic       cfg_err;
    logic [1:0] ce_o;
    logic [1:0] outclk;
    logic       locked;

    // Free-running reference clock.
    always #5 refclk = ~refclk;

    pll_clken_gen #(
        .NUM_CLOCKS  (NCH),
        .ACC_W       (AW),
        .LOCK_CYCLES (LC),
        .INC_INIT    (INIT)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .ce_o      (ce_o),
        .outclk    (outclk),
        .locked    (locked)
    );

    typedef struct {
        logic [1:0] ce;
        logic [1:0] oc;
        logic       lk;
        logic       err;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: the rate of each channel is phase + k*inc,
    // and a pulse is due whenever the integer part of that value over 256 steps up.
    int         m_inc[NCH];
    int         m_phase[NCH];
    int         m_steps[NCH];
    logic [1:0] m_oc;
    logic       m_lk;
    logic       m_rdy;
    int         m_stable;

    function automatic int wraps(input int phase, input int inc, input int k);
        return (phase + k * inc) / 256;
    endfunction

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("ce_o",      {6'd0, ce_o},      {6'd0, e.ce});
        cmp("outclk",    {6'd0, outclk},    {6'd0, e.oc});
        cmp("locked",    {7'd0, locked},    {7'd0, e.lk});
        cmp("cfg_err",   {7'd0, cfg_err},   {7'd0, e.err});
        cmp("cfg_ready", {7'd0, cfg_ready}, {7'd0, e.rdy});
    endtask

    // Advance the model by one rising edge using the inputs the DUT just sampled.
    task automatic modelEdge();
        exp_t       e;
        logic       fire;
        logic [7:0] init_v;
        e.ce  = 2'b00;
        e.err = 1'b0;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                init_v     = INIT[c*8 +: 8];
                m_inc[c]   = int'(init_v);
                m_phase[c] = 0;
                m_steps[c] = 0;
            end
            m_oc     = 2'b00;
            m_lk     = 1'b0;
            m_rdy    = 1'b0;
            m_stable = 0;
            e.rdy    = 1'b0;
        end else begin
            fire = cfg_valid && m_rdy;
            if (fire && (int'(cfg_ch) < NCH)) begin
                m_inc[cfg_ch] = int'(cfg_inc);
                for (int c = 0; c < NCH; c++) begin
                    m_phase[c] = (c == int'(cfg_ch)) ? int'(cfg_phase) : 0;
                    m_steps[c] = 0;
                end
                m_oc     = 2'b00;
                m_lk     = 1'b0;
                m_stable = 0;
            end else begin
                if (fire) e.err = 1'b1;
                if (m_lk) begin
                    for (int c = 0; c < NCH; c++) begin
                        m_steps[c]++;
                        if (wraps(m_phase[c], m_inc[c], m_steps[c]) !=
                            wraps(m_phase[c], m_inc[c], m_steps[c] - 1)) begin
                            e.ce[c]  = 1'b1;
                            m_oc[c]  = ~m_oc[c];
                        end
                        if (m_inc[c] == 0) m_oc[c] = 1'b0;
                    end
                end
                m_stable++;
                m_lk = (m_stable >= LC + 1);
            end
            m_rdy = 1'b1;
            e.rdy = 1'b1;
        end
        e.oc = m_oc;
        e.lk = m_lk;
        sb.push_back(e);
    endtask

    task automatic stepCycle();
        @(posedge refclk);
        #1;
        modelEdge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic applyStimulus(input logic [3:0] ch, input logic [7:0] inc, input logic [7:0] phase);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = phase;
        stepCycle();
        cfg_valid = 1'b0;
    endtask

    // Monitor: compare each queued prediction on the falling edge, clear of the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge refclk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    // Driver: directed scenarios, then a randomized mix of writes and resets.
    initial begin
        int cnt0;
        int cnt1;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = 4'd0;
        cfg_inc   = 8'd0;
        cfg_phase = 8'd0;
        idle(3);
        rst = 1'b0;
        idle(45);

        applyStimulus(4'd1, 8'h55, 8'h00);
        idle(5);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 256; i++) begin
            stepCycle();
            cnt0 += int'(ce_o[0]);
            cnt1 += int'(ce_o[1]);
        end
        cmp("ch1_pulses_in_256", 8'(cnt1), 8'd85);
        cmp("ch0_pulses_in_256", 8'(cnt0 / 2), 8'd64);

        applyStimulus(4'd0, 8'h80, 8'h80);
        idle(20);
        applyStimulus(4'd0, 8'h00, 8'h00);
        idle(110);
        applyStimulus(4'd3, 8'h12, 8'h34);
        idle(20);

        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(50);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                stepCycle();
                rst = 1'b0;
            end
            applyStimulus(4'($urandom_range(0, 3)),
                          ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                          8'($urandom));
            idle($urandom_range(0, 40));
        end

        idle(2);
        repeat (4) @(negedge refclk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
